// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX register and the MEM stage.
//   - Resolves operand forwarding from MEM (highest priority) and WB.
//   - Single-cycle ALU: ADD/SUB/AND/OR/XOR/NOR/SLL/SRL/SRA/SLT/PASSB.
//   - MUL runs on an iterative shift-add multiplier that holds the front
//     end through ex_busy while it iterates.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_ex_in[64:0]    {alu_op, use_imm, src1_id, src2_id, src1_val, src2_val,
//                      imm, mem_write, wb_en, dest, mem_read}
//   mem_fwd_val/dest  MEM-stage result and destination (dest 0 = none)
//   wb_fwd_val/dest   write-back value and destination (dest 0 = none)
//   freeze            hold all state (MEM/cache stall)
//   flush             replace the current op with a bubble
//   pipeline_reg_out  registered EX/MEM bundle
//                     {result[37:22], mem_write, store_data[20:5], wb_en, dest, mem_read}
//   ex_busy           multiplier owns the stage; upstream holds id_ex_in
//   ex_op_dest        dest when wb_en, else 0 (for hazard detection)
module ex_stage #(
    parameter int DW         = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:0] id_ex_in,
    input  logic [15:0] mem_fwd_val,
    input  logic [2:0]  mem_fwd_dest,
    input  logic [15:0] wb_fwd_val,
    input  logic [2:0]  wb_fwd_dest,
    input  logic        freeze,
    input  logic        flush,
    output logic [37:0] pipeline_reg_out,
    output logic        ex_busy,
    output logic [2:0]  ex_op_dest
);

    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operand selection: MEM forward beats WB forward; register 0 never forwards.
    function automatic logic [15:0] fwd_sel(
        input logic [2:0]  src_id,
        input logic [15:0] field_val,
        input logic [2:0]  m_dest,
        input logic [15:0] m_val,
        input logic [2:0]  w_dest,
        input logic [15:0] w_val
    );
        logic [15:0] sel;
        if ((src_id != 3'd0) && (src_id == m_dest)) begin
            sel = m_val;
        end else if ((src_id != 3'd0) && (src_id == w_dest)) begin
            sel = w_val;
        end else begin
            sel = field_val;
        end
        return sel;
    endfunction

    logic [3:0]  alu_op_s;
    logic        use_imm_s;
    logic [2:0]  src1_id_s, src2_id_s;
    logic [15:0] src1_val_s, src2_val_s, imm_s;
    logic        mem_write_s, wb_en_s, mem_read_s;
    logic [2:0]  dest_s;

    assign alu_op_s    = id_ex_in[64:61];
    assign use_imm_s   = id_ex_in[60];
    assign src1_id_s   = id_ex_in[59:57];
    assign src2_id_s   = id_ex_in[56:54];
    assign src1_val_s  = id_ex_in[53:38];
    assign src2_val_s  = id_ex_in[37:22];
    assign imm_s       = id_ex_in[21:6];
    assign mem_write_s = id_ex_in[5];
    assign wb_en_s     = id_ex_in[4];
    assign dest_s      = id_ex_in[3:1];
    assign mem_read_s  = id_ex_in[0];

    logic [15:0] op_a_s, src2_fwd_s, op_b_s, alu_res_s;
    logic [31:0] mul_full_s;

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r;
    logic [15:0] mcand_r, mplier_r, acc_r;
    logic [37:0] bundle_r;
    logic        busy_s;

    assign op_a_s     = fwd_sel(src1_id_s, src1_val_s, mem_fwd_dest, mem_fwd_val, wb_fwd_dest, wb_fwd_val);
    assign src2_fwd_s = fwd_sel(src2_id_s, src2_val_s, mem_fwd_dest, mem_fwd_val, wb_fwd_dest, wb_fwd_val);
    assign op_b_s     = use_imm_s ? imm_s : src2_fwd_s;
    assign mul_full_s = {16'd0, op_a_s} * {16'd0, op_b_s};

    // Single-cycle ALU result; MUL here is only a fallback, the FSM supplies the real product.
    always_comb begin
        alu_res_s = 16'd0;
        case (alu_op_s)
            4'd0:    alu_res_s = op_a_s + op_b_s;
            4'd1:    alu_res_s = op_a_s - op_b_s;
            4'd2:    alu_res_s = op_a_s & op_b_s;
            4'd3:    alu_res_s = op_a_s | op_b_s;
            4'd4:    alu_res_s = op_a_s ^ op_b_s;
            4'd5:    alu_res_s = ~(op_a_s | op_b_s);
            4'd6:    alu_res_s = op_a_s << op_b_s[3:0];
            4'd7:    alu_res_s = op_a_s >> op_b_s[3:0];
            4'd8:    alu_res_s = 16'($signed(op_a_s) >>> op_b_s[3:0]);
            4'd9:    alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? 16'd1 : 16'd0;
            4'd10:   alu_res_s = op_b_s;
            4'd11:   alu_res_s = mul_full_s[15:0];
            default: alu_res_s = 16'd0;
        endcase
    end

    // Multiplier FSM next state and stall request.
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (alu_op_s == OP_MUL) begin
                    busy_s      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, multiplier datapath and EX/MEM bundle register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            mcand_r  <= 16'd0;
            mplier_r <= 16'd0;
            acc_r    <= 16'd0;
            bundle_r <= 38'd0;
        end else if (freeze) begin
            state_r  <= state_r;
            cnt_r    <= cnt_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            bundle_r <= bundle_r;
        end else if (flush) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            bundle_r <= 38'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (alu_op_s == OP_MUL) begin
                        // Operands are snapshotted here; forwarding may change during the stall.
                        mcand_r  <= op_a_s;
                        mplier_r <= op_b_s;
                        acc_r    <= 16'd0;
                        cnt_r    <= 4'd0;
                        bundle_r <= 38'd0;
                    end else begin
                        bundle_r <= {alu_res_s, mem_write_s, src2_fwd_s, wb_en_s, dest_s, mem_read_s};
                    end
                end
                ST_RUN: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 4'd1;
                    bundle_r <= 38'd0;
                end
                ST_DONE: begin
                    bundle_r <= {acc_r, mem_write_s, src2_fwd_s, wb_en_s, dest_s, mem_read_s};
                end
                default: begin
                    bundle_r <= 38'd0;
                end
            endcase
        end
    end

    assign pipeline_reg_out = bundle_r;
    assign ex_busy          = busy_s;
    assign ex_op_dest       = wb_en_s ? dest_s : 3'd0;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand-written
// multi-cycle sequences (MUL, freeze, flush, reset) and randomized ops
// checked against a behavioural model.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [64:0] id_ex_in;
    logic [15:0] mem_fwd_val;
    logic [2:0]  mem_fwd_dest;
    logic [15:0] wb_fwd_val;
    logic [2:0]  wb_fwd_dest;
    logic        freeze;
    logic        flush;
    logic [37:0] pipeline_reg_out;
    logic        ex_busy;
    logic [2:0]  ex_op_dest;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .id_ex_in         (id_ex_in),
        .mem_fwd_val      (mem_fwd_val),
        .mem_fwd_dest     (mem_fwd_dest),
        .wb_fwd_val       (wb_fwd_val),
        .wb_fwd_dest      (wb_fwd_dest),
        .freeze           (freeze),
        .flush            (flush),
        .pipeline_reg_out (pipeline_reg_out),
        .ex_busy          (ex_busy),
        .ex_op_dest       (ex_op_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        use_imm;
        logic [2:0]  s1_id;
        logic [2:0]  s2_id;
        logic [15:0] s1_val;
        logic [15:0] s2_val;
        logic [15:0] imm;
        logic [2:0]  m_dest;
        logic [15:0] m_val;
        logic [2:0]  w_dest;
        logic [15:0] w_val;
        logic        wb;
        logic [2:0]  dest;
        logic [15:0] exp_res;
        logic [2:0]  exp_odest;
    } vec_t;

    function automatic logic [64:0] pack(
        input logic [3:0] op, input logic ui, input logic [2:0] s1, input logic [2:0] s2,
        input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] im,
        input logic mw, input logic wb, input logic [2:0] d, input logic mr);
        return {op, ui, s1, s2, v1, v2, im, mw, wb, d, mr};
    endfunction

    // Reference model: operand forwarding by priority.
    function automatic logic [15:0] m_fwd(input logic [2:0] id, input logic [15:0] v,
        input logic [2:0] md, input logic [15:0] mv, input logic [2:0] wd, input logic [15:0] wv);
        if (id != 3'd0 && id == md) return mv;
        if (id != 3'd0 && id == wd) return wv;
        return v;
    endfunction

    // Reference model: arithmetic on plain integers, modulo 2^16.
    function automatic logic [15:0] m_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned sh;
        int sa, sb;
        longint unsigned prod;
        sh = int'(b) % 16;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        prod = longint'(a) * longint'(b);
        case (op)
            4'd0:    return 16'((int'(a) + int'(b)) % 65536);
            4'd1:    return 16'((int'(a) - int'(b) + 65536) % 65536);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return 16'((longint'(a) * (longint'(1) << sh)) % 65536);
            4'd7:    return 16'(int'(a) / (1 << sh));
            4'd8:    return 16'($floor(real'(sa) / real'(1 << sh)));
            4'd9:    return (sa < sb) ? 16'd1 : 16'd0;
            4'd10:   return b;
            4'd11:   return 16'(prod % 65536);
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [37:0] m_bundle(input logic [64:0] ins,
        input logic [2:0] md, input logic [15:0] mv, input logic [2:0] wd, input logic [15:0] wv);
        logic [15:0] a, s2f, b;
        a   = m_fwd(ins[59:57], ins[53:38], md, mv, wd, wv);
        s2f = m_fwd(ins[56:54], ins[37:22], md, mv, wd, wv);
        b   = ins[60] ? ins[21:6] : s2f;
        return {m_alu(ins[64:61], a, b), ins[5], s2f, ins[4], ins[3:1], ins[0]};
    endfunction

    task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        mem_fwd_dest = 3'd0;
        mem_fwd_val  = 16'd0;
        wb_fwd_dest  = 3'd0;
        wb_fwd_val   = 16'd0;
    endtask

    // Issue a MUL, optionally freezing frz_len cycles starting at cycle frz_at (must be in RUN).
    task automatic do_mul(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input int frz_at, input int frz_len);
        logic [37:0] exp;
        exp = {m_alu(4'd11, a, b), 1'b0, b, 1'b1, d, 1'b0};
        clear_fwd();
        id_ex_in = pack(4'd11, 1'b0, 3'd0, 3'd0, a, b, 16'd0, 1'b0, 1'b1, d, 1'b0);
        #1;
        chk({nm, "_busy_issue"}, {37'd0, ex_busy}, 38'd1);
        for (int k = 0; k <= 16 + frz_len; k++) begin
            freeze = (k >= frz_at && k < frz_at + frz_len) ? 1'b1 : 1'b0;
            // Noisy forwarding after issue must not disturb the snapshot.
            if (k > 0) begin
                mem_fwd_dest = 3'($urandom_range(0, 7));
                mem_fwd_val  = 16'($urandom);
            end
            tick();
            chk({nm, "_bubble"}, pipeline_reg_out, 38'd0);
            chk({nm, "_busy"}, {37'd0, ex_busy}, {37'd0, (k + 1 <= 16 + frz_len) ? 1'b1 : 1'b0});
        end
        freeze = 1'b0;
        tick();
        chk({nm, "_result"}, pipeline_reg_out, exp);
        id_ex_in = 65'd0;
        clear_fwd();
    endtask

    vec_t vecs[12];

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; id_ex_in = 65'd0;
        clear_fwd();

        vecs[0]  = '{4'd0, 1'b0, 3'd3, 3'd0, 16'h0001, 16'h0010, 16'h0, 3'd3, 16'h1234, 3'd3, 16'h5555, 1'b1, 3'd4, 16'h1244, 3'd4};
        vecs[1]  = '{4'd9, 1'b0, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 16'h0, 3'd0, 16'h0,    3'd0, 16'h0,    1'b1, 3'd1, 16'h0001, 3'd1};
        vecs[2]  = '{4'd8, 1'b1, 3'd0, 3'd0, 16'h8000, 16'h0000, 16'h4, 3'd0, 16'h0,    3'd0, 16'h0,    1'b0, 3'd2, 16'hF800, 3'd0};
        vecs[3]  = '{4'd1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0001, 16'h0, 3'd0, 16'h0,    3'd0, 16'h0,    1'b1, 3'd7, 16'hFFFF, 3'd7};
        vecs[4]  = '{4'd0, 1'b0, 3'd2, 3'd0, 16'h0001, 16'h0010, 16'h0, 3'd5, 16'h1234, 3'd2, 16'h5555, 1'b1, 3'd2, 16'h5565, 3'd2};
        vecs[5]  = '{4'd0, 1'b0, 3'd0, 3'd0, 16'h0001, 16'h0002, 16'h0, 3'd0, 16'h7777, 3'd0, 16'h5555, 1'b1, 3'd2, 16'h0003, 3'd2};
        vecs[6]  = '{4'd5, 1'b0, 3'd0, 3'd0, 16'h00F0, 16'h0F00, 16'h0, 3'd0, 16'h0,    3'd0, 16'h0,    1'b1, 3'd3, 16'hF00F, 3'd3};
        vecs[7]  = '{4'd6, 1'b1, 3'd0, 3'd0, 16'h0003, 16'h0000, 16'h11, 3'd0, 16'h0,   3'd0, 16'h0,    1'b1, 3'd3, 16'h0006, 3'd3};
        vecs[8]  = '{4'd7, 1'b1, 3'd0, 3'd0, 16'h8000, 16'h0000, 16'hF, 3'd0, 16'h0,    3'd0, 16'h0,    1'b1, 3'd3, 16'h0001, 3'd3};
        vecs[9]  = '{4'd10, 1'b1, 3'd0, 3'd0, 16'h1111, 16'h2222, 16'hABCD, 3'd0, 16'h0, 3'd0, 16'h0,   1'b1, 3'd6, 16'hABCD, 3'd6};
        vecs[10] = '{4'd13, 1'b0, 3'd0, 3'd0, 16'h1111, 16'h2222, 16'h0, 3'd0, 16'h0,   3'd0, 16'h0,    1'b1, 3'd6, 16'h0000, 3'd6};
        vecs[11] = '{4'd0, 1'b0, 3'd0, 3'd1, 16'h0100, 16'h0002, 16'h0, 3'd1, 16'h00F0, 3'd0, 16'h0,    1'b1, 3'd1, 16'h01F0, 3'd1};

        // Reset state.
        tick();
        tick();
        chk("reset_bundle", pipeline_reg_out, 38'd0);
        chk("reset_busy", {37'd0, ex_busy}, 38'd0);
        chk("reset_odest", {35'd0, ex_op_dest}, 38'd0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            id_ex_in = pack(vecs[i].op, vecs[i].use_imm, vecs[i].s1_id, vecs[i].s2_id,
                            vecs[i].s1_val, vecs[i].s2_val, vecs[i].imm,
                            1'b0, vecs[i].wb, vecs[i].dest, 1'b0);
            mem_fwd_dest = vecs[i].m_dest; mem_fwd_val = vecs[i].m_val;
            wb_fwd_dest  = vecs[i].w_dest; wb_fwd_val  = vecs[i].w_val;
            #1;
            chk($sformatf("vec%0d_odest", i), {35'd0, ex_op_dest}, {35'd0, vecs[i].exp_odest});
            tick();
            chk($sformatf("vec%0d_res", i), {22'd0, pipeline_reg_out[37:22]}, {22'd0, vecs[i].exp_res});
        end

        // Freeze holds a single-cycle result.
        clear_fwd();
        id_ex_in = pack(4'd0, 1'b0, 3'd0, 3'd0, 16'h0005, 16'h0006, 16'h0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        chk("sc_store", pipeline_reg_out, {16'h000B, 1'b1, 16'h0006, 1'b0, 3'd0, 1'b0});
        freeze = 1'b1;
        id_ex_in = pack(4'd2, 1'b0, 3'd0, 3'd0, 16'h00FF, 16'h0F0F, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1);
        tick();
        chk("freeze_hold", pipeline_reg_out, {16'h000B, 1'b1, 16'h0006, 1'b0, 3'd0, 1'b0});
        freeze = 1'b0;
        flush = 1'b1;
        tick();
        chk("flush_single", pipeline_reg_out, 38'd0);
        flush = 1'b0;

        // MUL: plain, then with a 3-cycle freeze mid-RUN.
        do_mul("mul", 16'h0123, 16'h0045, 3'd5, 100, 0);
        do_mul("mul_frz", 16'h0123, 16'h0045, 3'd5, 6, 3);

        // Flush at counter 7 aborts the multiply.
        id_ex_in = pack(4'd11, 1'b0, 3'd0, 3'd0, 16'h0123, 16'h0045, 16'h0, 1'b0, 1'b1, 3'd5, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_mul_bundle", pipeline_reg_out, 38'd0);
        id_ex_in = pack(4'd0, 1'b0, 3'd0, 3'd0, 16'h0005, 16'h0007, 16'h0, 1'b0, 1'b1, 3'd3, 1'b0);
        #1;
        chk("flush_mul_busy", {37'd0, ex_busy}, 38'd0);
        tick();
        chk("flush_then_add", pipeline_reg_out, {16'h000C, 1'b0, 16'h0007, 1'b1, 3'd3, 1'b0});

        // Reset together with freeze in the middle of a multiply.
        id_ex_in = pack(4'd11, 1'b0, 3'd0, 3'd0, 16'h0F0F, 16'h0033, 16'h0, 1'b0, 1'b1, 3'd5, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1; freeze = 1'b1;
        tick();
        chk("rst_frz_bundle", pipeline_reg_out, 38'd0);
        rst = 1'b0; freeze = 1'b0;
        id_ex_in = pack(4'd4, 1'b0, 3'd0, 3'd0, 16'h00FF, 16'h0F0F, 16'h0, 1'b0, 1'b1, 3'd6, 1'b0);
        #1;
        chk("rst_frz_busy", {37'd0, ex_busy}, 38'd0);
        tick();
        chk("rst_then_xor", pipeline_reg_out, {16'h0FF0, 1'b0, 16'h0F0F, 1'b1, 3'd6, 1'b0});

        // Randomized single-cycle ops against the model.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd11) op = 4'd0;
            id_ex_in = pack(op, 1'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                            16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                            3'($urandom), 1'($urandom));
            mem_fwd_dest = 3'($urandom); mem_fwd_val = 16'($urandom);
            wb_fwd_dest  = 3'($urandom); wb_fwd_val  = 16'($urandom);
            #1;
            chk("rnd_odest", {35'd0, ex_op_dest}, {35'd0, id_ex_in[4] ? id_ex_in[3:1] : 3'd0});
            begin
                logic [37:0] exp;
                exp = m_bundle(id_ex_in, mem_fwd_dest, mem_fwd_val, wb_fwd_dest, wb_fwd_val);
                tick();
                chk($sformatf("rnd%0d_op%0d", i, op), pipeline_reg_out, exp);
            end
        end

        // Randomized multiplies.
        for (int i = 0; i < 4; i++) begin
            do_mul("rnd_mul", 16'($urandom), 16'($urandom), 3'($urandom_range(1, 7)),
                   int'($urandom_range(1, 10)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage between the ID/EX register and MEM stage. Resolves operand forwarding from MEM and WB, performs ALU operations, and runs an iterative 16-cycle shift-add multiplier that stalls the front end. Registers results into the 38-bit EX/MEM bundle consumed by MEM: [37:22] address/result, [21] mem write, [20:5] store data, [4] wb_en, [3:1] dest, [0] mem read.

Parameters:
DW, 16, datapath width; fixed, since MEM bundle layout depends on it
MUL_CYCLES, 16, multiplier iterations; equals DW

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_ex_in  in  65  [64:61] alu_op, [60] use_imm, [59:57] src1_id, [56:54] src2_id, [53:38] src1_val, [37:22] src2_val, [21:6] imm, [5] mem_write, [4] wb_en, [3:1] dest, [0] mem_read
mem_fwd_val  in  16  result currently in MEM stage
mem_fwd_dest  in  3  MEM destination; 0 = none
wb_fwd_val  in  16  value being written back
wb_fwd_dest  in  3  WB destination; 0 = none
freeze  in  1  MEM/cache stall; hold all state
flush  in  1  replace current op with bubble
pipeline_reg_out  out  38  EX/MEM bundle, registered
ex_busy  out  1  multiplier occupying stage; upstream holds id_ex_in
ex_op_dest  out  3  hazard-detection destination: dest if wb_en else 0

Behaviour:
- Reset: pipeline_reg_out=0, state=IDLE, counter=0, multiplier registers=0. ex_busy=0 and ex_op_dest=0 follow from the reset input state.
- Priority at each edge: rst > freeze > flush > normal.
- Forwarding, per source, combinational:
  - if src_id!=0 and src_id==mem_fwd_dest, use mem_fwd_val;
  - else if src_id!=0 and src_id==wb_fwd_dest, use wb_fwd_val;
  - else use the field value.
  - MEM wins over WB. Forwarded src2 is the store data.
- Operand B = imm if use_imm else forwarded src2.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA; shift amount is B[3:0].
  - 9 SLT: signed compare, result 1/0.
  - 10 PASSB.
  - 11 MUL: low 16 bits of unsigned product.
  - 12-15: result 0.
- Arithmetic wraps modulo 2^16; no flags.
- Single-cycle ops: 1-cycle latency. Normal edge loads {result, mem_write, store_data, wb_en, dest, mem_read}.
- Flush (no freeze): pipeline_reg_out<=0, state->IDLE, counter cleared. This aborts any multiply.
- Freeze: pipeline_reg_out, state and counter all hold.
- MUL FSM:
  - IDLE: if alu_op==11, ex_busy=1 combinationally. At the edge: latch forwarded A and B into multiplicand/multiplier, acc=0, counter=0, pipeline_reg_out<=0 (bubble), state->RUN.
  - RUN: ex_busy=1. Each edge: if multiplier LSB, acc+=multiplicand. Then multiplicand<<=1, multiplier>>=1, counter++. Edge with counter==15 -> DONE. pipeline_reg_out<=0 on every RUN edge.
  - DONE: ex_busy=0. Edge loads pipeline_reg_out with acc as result plus control fields from id_ex_in. state->IDLE. Upstream advances the same edge.
- MUL timing: issue cycle 0; ex_busy high cycles 0-16; result visible in pipeline_reg_out from cycle 18. Freeze cycles extend this one-for-one.
- Operand capture: forwarded values change while stalled, so only the IDLE-edge snapshot is used. id_ex_in control fields must stay stable while ex_busy=1.
- ex_op_dest is computed from id_ex_in and is valid in all states. It is 0 when wb_en=0.

Test Plan:
- ADD src1=3 (val 0x0001), mem_fwd_dest=3 mem_fwd_val=0x1234, wb_fwd_dest=3 wb_fwd_val=0x5555, src2 val 0x0010 -> next cycle [37:22]=0x1244 (MEM priority).
- SLT A=0xFFFF, B=0x0001 -> result 0x0001. SRA A=0x8000, B=4 -> 0xF800. SUB 0x0000-0x0001 -> 0xFFFF.
- MUL 0x0123 x 0x0045, wb_en=1, dest=5 -> ex_busy high 17 cycles; bundle zero cycles 1-17; cycle 18 result 0x4E6F, [4:1]=4'b1101.
- Freeze held 3 cycles mid-RUN -> counter and bundle frozen; result appears at cycle 21, same value.
- Flush at RUN counter=7 -> bundle 0, ex_busy drops next cycle, FSM IDLE. A new ADD completes normally.
- rst asserted mid-MUL, with freeze simultaneously high -> next cycle bundle 0, IDLE, ex_busy reflects only id_ex_in.
